apb_fnd_scan: RTL and testbench

//  APB3 slave driving a multiplexed, common-anode 7-segment display of N_DIGITS.

---
 rtl/apb_fnd_scan_if.sv | 20 ++
 rtl/apb_fnd_scan.sv | 149 ++++++++++++++
 tb/tb_apb_fnd_scan.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_fnd_scan_if.sv
// APB3 bus bundle between a master and the apb_fnd_scan display peripheral.
interface apb_fnd_scan_if;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PENABLE, PSEL,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fnd_scan.sv
// APB3 slave that autonomously scans a multiplexed common-anode 7-segment display.
// Register map: 0x0 FCR (EN), 0x4 FDR (hex nibbles), 0x8 FMR (dp/blank), 0xC FPSR (prescaler).
module apb_fnd_scan #(
    parameter int N_DIGITS  = 4,
    parameter int PRESC_W   = 16,
    parameter int PRESC_RST = 49999
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_fnd_scan_if.slave       apb,
    output logic [7:0]          fndFont,
    output logic [N_DIGITS-1:0] fndComm
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic {S_OFF, S_SCAN} state_e;

    logic                  en_q, en_d;
    logic [4*N_DIGITS-1:0] fdr_q, fdr_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   blank_q, blank_d;
    logic [PRESC_W-1:0]    fpsr_q, fpsr_d;
    logic                  pready_q, pready_d;
    logic [31:0]           prdata_q, prdata_d;

    state_e                state_q;
    logic [PRESC_W-1:0]    cnt_q;
    logic [IDX_W-1:0]      idx_q;
    logic [7:0]            font_q;
    logic [N_DIGITS-1:0]   comm_q;

    logic                  wr_commit;
    logic                  rd_launch;
    logic [31:0]           rdata;
    logic                  unused;

    // Segment pattern g..a, active-low, for one hex nibble.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_commit = apb.PSEL & apb.PENABLE & apb.PWRITE & pready_q;
        rd_launch = apb.PSEL & apb.PENABLE & ~apb.PWRITE & ~pready_q;
        pready_d  = apb.PSEL & apb.PENABLE & ~pready_q;

        rdata = '0;
        case (apb.PADDR[3:2])
            2'd0: rdata[0] = en_q;
            2'd1: rdata[4*N_DIGITS-1:0] = fdr_q;
            2'd2: begin
                rdata[N_DIGITS-1:0]   = dp_q;
                rdata[8+N_DIGITS-1:8] = blank_q;
            end
            default: rdata[PRESC_W-1:0] = fpsr_q;
        endcase
        prdata_d = rd_launch ? rdata : prdata_q;

        en_d    = en_q;
        fdr_d   = fdr_q;
        dp_d    = dp_q;
        blank_d = blank_q;
        fpsr_d  = fpsr_q;
        if (wr_commit) begin
            case (apb.PADDR[3:2])
                2'd0: en_d = apb.PWDATA[0];
                2'd1: fdr_d = apb.PWDATA[4*N_DIGITS-1:0];
                2'd2: begin
                    dp_d    = apb.PWDATA[N_DIGITS-1:0];
                    blank_d = apb.PWDATA[8+N_DIGITS-1:8];
                end
                default: fpsr_d = apb.PWDATA[PRESC_W-1:0];
            endcase
        end
    end

    assign unused = &{1'b0, apb.PADDR[1:0], apb.PWDATA};

    always_ff @(posedge PCLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (PRESET) begin
            en_q     <= 1'b0;
            fdr_q    <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
            fpsr_q   <= PRESC_W'(PRESC_RST);
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            en_q     <= en_d;
            fdr_q    <= fdr_d;
            dp_q     <= dp_d;
            blank_q  <= blank_d;
            fpsr_q   <= fpsr_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    // Scan FSM; outputs are registered from the current state/idx, one cycle behind.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            font_q  <= 8'hFF;
            comm_q  <= '1;
        end else begin
            if (state_q == S_SCAN && !blank_q[idx_q]) begin
                comm_q <= ~(N_DIGITS'(1) << idx_q);
                font_q <= {~dp_q[idx_q], seg7(fdr_q[{idx_q, 2'b00} +: 4])};
            end else begin
                comm_q <= '1;
                font_q <= 8'hFF;
            end

            case (state_q)
                S_OFF: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (en_d) state_q <= S_SCAN;
                end
                default: begin
                    if (!en_d) begin
                        state_q <= S_OFF;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else if (cnt_q >= fpsr_q) begin
                        cnt_q <= '0;
                        idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_q <= cnt_q + PRESC_W'(1);
                    end
                end
            endcase
        end
    end

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign fndFont     = font_q;
    assign fndComm     = comm_q;
endmodule

// File: tb/tb_apb_fnd_scan.sv
// Directed bench for apb_fnd_scan: register access, scan timing, masks, prescaler, reset abort.
module tb_apb_fnd_scan;
    localparam int N  = 4;
    localparam int PW = 16;
    localparam int PR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] font;
    logic [3:0] comm;
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    apb_fnd_scan_if bus ();

    apb_fnd_scan #(.N_DIGITS(N), .PRESC_W(PW), .PRESC_RST(PR)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .apb    (bus),
        .fndFont(font),
        .fndComm(comm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] c);
        return {c[2:0], c[3]};
    endfunction

    // Expected font for each digit enable while FDR=0x4321, FMR=0x0201.
    function automatic logic [7:0] exp_font_masked(input logic [3:0] c);
        case (c)
            4'hE:    return 8'h79;
            4'hB:    return 8'hB0;
            4'h7:    return 8'h99;
            4'hF:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    // Returns 1 ns after the edge that commits the write.
    task automatic apb_write(input logic [3:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = addr; bus.PWDATA = data;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic apb_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        check({tag, "_wait"}, bus.PREADY, 1'b0);
        @(posedge clk); #1;
        check({tag, "_ready"}, bus.PREADY, 1'b1);
        check({tag, "_data"}, bus.PRDATA, exp);
        @(posedge clk); #1;
        check({tag, "_done"}, bus.PREADY, 1'b0);
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] font_exp [4];
        logic [3:0] comm_exp [4];
        logic [3:0] c0;
        int         dark;

        font_exp = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        comm_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        bus_idle();
        bus.PADDR  = '0;
        bus.PWDATA = '0;

        // 1. Reset state and register reads.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_pready", bus.PREADY, 1'b0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        check("rst_font", font, 8'hFF);
        check("rst_comm", comm, 4'hF);
        apb_read("rd_fcr", 4'h0, 32'h0);
        apb_read("rd_fdr", 4'h4, 32'h0);
        apb_read("rd_fmr", 4'h8, 32'h0);
        apb_read("rd_fpsr", 4'hC, 32'd3);

        // 2. Scan order and timing; unused FDR bits are not stored.
        apb_write(4'h4, 32'hFFFF_4321);
        apb_read("rd_fdr_trim", 4'h4, 32'h0000_4321);
        check("off_font", font, 8'hFF);
        apb_write(4'h0, 32'h1);
        check("en_first_font", font, 8'hFF);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("scan_comm%0d", k), comm, comm_exp[k % 4]);
            check($sformatf("scan_font%0d", k), font, font_exp[k % 4]);
            if (k == 0) begin
                repeat (3) @(posedge clk); #1;
                check("scan_hold", comm, 4'hE);
                @(posedge clk); #1;
            end else if (k < 4) begin
                repeat (4) @(posedge clk); #1;
            end
        end

        // 3. Decimal point on digit 0, digit 1 blanked.
        apb_write(4'h8, 32'h0000_0201);
        repeat (2) @(posedge clk); #1;
        dark = 0;
        for (int k = 0; k < 16; k++) begin
            check("mask_font", font, exp_font_masked(comm));
            if (comm == 4'hF) dark++;
            @(posedge clk); #1;
        end
        check("mask_dark_cycles", dark, 4);
        apb_read("rd_fmr2", 4'h8, 32'h0000_0201);

        // 4. Lowering FPSR below cnt ticks on the next edge.
        apb_write(4'h8, 32'h0);
        apb_write(4'hC, 32'd1000);
        repeat (5) @(posedge clk);
        apb_write(4'hC, 32'd2);
        c0 = comm;
        @(posedge clk); #1;
        check("presc_hold", comm, c0);
        @(posedge clk); #1;
        check("presc_tick_next", comm, rotl(c0));
        c0 = comm;
        for (int p = 0; p < 4; p++) begin
            repeat (2) @(posedge clk); #1;
            check("presc_stay", comm, c0);
            @(posedge clk); #1;
            check("presc_step", comm, rotl(c0));
            c0 = comm;
        end

        // FPSR=0: advance every cycle.
        apb_write(4'hC, 32'd0);
        repeat (2) @(posedge clk); #1;
        c0 = comm;
        for (int p = 0; p < 4; p++) begin
            @(posedge clk); #1;
            check("presc0_step", comm, rotl(c0));
            c0 = comm;
        end

        // 6. Disable mid-scan, then re-enable restarts at digit 0.
        apb_write(4'hC, 32'd3);
        apb_write(4'h0, 32'h0);
        @(posedge clk); #1;
        check("dis_comm", comm, 4'hF);
        check("dis_font", font, 8'hFF);
        apb_write(4'h0, 32'h1);
        @(posedge clk); #1;
        check("reen_comm", comm, 4'hE);
        check("reen_font", font, 8'hF9);
        repeat (4) @(posedge clk); #1;
        check("reen_comm1", comm, 4'hD);
        check("reen_font1", font, 8'hA4);

        // 5. Reset during the PREADY cycle of a write drops the write.
        @(posedge clk); #1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 4'h4; bus.PWDATA = 32'h0000_9999;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        check("abort_pready_hi", bus.PREADY, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_font", font, 8'hFF);
        check("abort_comm", comm, 4'hF);
        check("abort_pready", bus.PREADY, 1'b0);
        bus_idle();
        rst = 1'b0;
        apb_read("abort_fdr", 4'h4, 32'h0);
        apb_read("abort_fcr", 4'h0, 32'h0);
        apb_read("abort_fpsr", 4'hC, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
